// File: rtl/scroll_pkg.sv
// Shared types and constants for the 7-segment scroll sequencer.
package scroll_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    READ      = 2'd2,
    CAPTURE   = 2'd3
  } seqState_t;

  localparam logic [3:0] BLANK_CODE_DEFAULT = 4'hF;
  localparam logic [7:0] ASCII_0            = 8'h30;
  localparam logic [7:0] ASCII_9            = 8'h39;

endpackage

// File: rtl/ascii_digit_decode.sv
// ASCII '0'..'9' to 4-bit digit code; anything else maps to the blank code.
module ascii_digit_decode
  import scroll_pkg::*;
#(
  parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEFAULT
) (
  input  logic [7:0] charIn,
  output logic [3:0] code,
  output logic       bad
);

  // Range check on the raw byte; low nibble of '0'..'9' is the digit itself.
  always_comb begin
    bad  = (charIn < ASCII_0) || (charIn > ASCII_9);
    code = bad ? BLANK_CODE : charIn[3:0];
  end

endmodule

// File: rtl/scroll_sequencer.sv
// Paces FIFO characters into a DIGITS-wide scroll window, one per rate tick.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | window blank, waiting for start
// WAIT_TICK | waiting for an unpaused tick; drains blanks if FIFO empty
// READ      | one-cycle FIFO pop strobe
// CAPTURE   | FIFO data valid; decode and shift into slot 0
module scroll_sequencer
  import scroll_pkg::*;
#(
  parameter int         DIGITS     = 3,
  parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_tick,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_abort,
  input  logic                i_fifo_empty,
  input  logic [7:0]          i_fifo_rd_data,
  output logic                o_fifo_rd_en,
  output logic [4*DIGITS-1:0] o_window,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_bad_char,
  output logic [7:0]          o_char_cnt
);

  localparam int                DW         = $clog2(DIGITS + 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(DIGITS - 1);
  localparam logic [4*DIGITS-1:0] WIN_BLANK = {DIGITS{BLANK_CODE}};

  seqState_t            state, nextState;
  logic [DW-1:0]        drainCnt;
  logic [4*DIGITS-1:0]  window;
  logic [7:0]           charCnt;
  logic                 doneQ, badQ;

  logic [3:0]           decCode;
  logic                 decBad;

  logic                 shiftEn, clearAll, drainInc, drainClr;
  logic                 cntInc, cntClr, doneSet, badSet;
  logic [3:0]           shiftCode;

  ascii_digit_decode #(.BLANK_CODE(BLANK_CODE)) uDecode (
    .charIn (i_fifo_rd_data),
    .code   (decCode),
    .bad    (decBad)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state and datapath controls; abort beats pause beats tick.
  always_comb begin
    nextState = state;
    shiftEn   = 1'b0;
    shiftCode = BLANK_CODE;
    clearAll  = 1'b0;
    drainInc  = 1'b0;
    drainClr  = 1'b0;
    cntInc    = 1'b0;
    cntClr    = 1'b0;
    doneSet   = 1'b0;
    badSet    = 1'b0;
    if (i_abort) begin
      nextState = IDLE;
      clearAll  = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            nextState = WAIT_TICK;
            cntClr    = 1'b1;
            drainClr  = 1'b1;
          end
        end
        WAIT_TICK: begin
          if (i_tick && !i_pause) begin
            if (!i_fifo_empty) begin
              nextState = READ;
            end else begin
              shiftEn  = 1'b1;
              drainInc = 1'b1;
              if (drainCnt == DRAIN_LAST) begin
                doneSet   = 1'b1;
                nextState = IDLE;
              end
            end
          end
        end
        READ: begin
          cntInc    = 1'b1;
          nextState = CAPTURE;
        end
        CAPTURE: begin
          shiftEn   = 1'b1;
          shiftCode = decCode;
          badSet    = decBad;
          drainClr  = 1'b1;
          nextState = WAIT_TICK;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // Window shift register, drain/char counters and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window   <= WIN_BLANK;
      drainCnt <= '0;
      charCnt  <= '0;
      doneQ    <= 1'b0;
      badQ     <= 1'b0;
    end else begin
      doneQ <= doneSet;
      badQ  <= badSet;
      if (clearAll)     window <= WIN_BLANK;
      else if (shiftEn) window <= {window[4*DIGITS-5:0], shiftCode};
      if (clearAll || drainClr) drainCnt <= '0;
      else if (drainInc)        drainCnt <= drainCnt + DW'(1);
      if (clearAll || cntClr) charCnt <= '0;
      else if (cntInc)        charCnt <= charCnt + 8'd1;
    end
  end

  assign o_fifo_rd_en = (state == READ);
  assign o_busy       = (state != IDLE);
  assign o_window     = window;
  assign o_done       = doneQ;
  assign o_bad_char   = badQ;
  assign o_char_cnt   = charCnt;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Scoreboard bench for scroll_sequencer: stimulus pushes expected events,
// a negedge monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_scroll_sequencer;

  localparam int         DIGITS = 3;
  localparam int         WBITS  = 4 * DIGITS;
  localparam logic [3:0] BLANK  = 4'hF;
  localparam logic [WBITS-1:0] WIN_BLANK = {DIGITS{BLANK}};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_tick = 1'b0, i_start = 1'b0, i_pause = 1'b0, i_abort = 1'b0;
  logic             i_fifo_empty = 1'b1;
  logic [7:0]       i_fifo_rd_data = 8'h00;
  logic             o_fifo_rd_en, o_busy, o_done, o_bad_char;
  logic [WBITS-1:0] o_window;
  logic [7:0]       o_char_cnt;

  scroll_sequencer #(.DIGITS(DIGITS), .BLANK_CODE(BLANK)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_tick         (i_tick),
    .i_start        (i_start),
    .i_pause        (i_pause),
    .i_abort        (i_abort),
    .i_fifo_empty   (i_fifo_empty),
    .i_fifo_rd_data (i_fifo_rd_data),
    .o_fifo_rd_en   (o_fifo_rd_en),
    .o_window       (o_window),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_bad_char     (o_bad_char),
    .o_char_cnt     (o_char_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  // Free-running cycle index used to timestamp expected events.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO: data appears the cycle after the pop strobe.
  logic [7:0] fifoQ[$];
  always @(posedge clk) begin
    if (o_fifo_rd_en && fifoQ.size() > 0) i_fifo_rd_data <= fifoQ.pop_front();
    i_fifo_empty <= (fifoQ.size() == 0);
  end

  typedef struct {
    int               cyc;
    logic [WBITS-1:0] win;
    logic             busy;
    logic             bad;
    logic             done;
  } ev_t;

  ev_t        evQ[$];
  int         rdQ[$];
  logic [7:0] mFifo[$];
  logic [WBITS-1:0] mWin = WIN_BLANK;
  bit         mRun = 0;
  int         mDrain = 0;
  int         mCnt = 0;

  int checks = 0;
  int errors = 0;
  bit monOn = 0;
  logic [WBITS-1:0] curWin = WIN_BLANK;
  logic curBusy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic pushEv(input int c, input logic [WBITS-1:0] w, input logic b,
                        input logic bad, input logic done);
    ev_t e;
    e.cyc = c; e.win = w; e.busy = b; e.bad = bad; e.done = done;
    evQ.push_back(e);
  endtask

  // Monitor: every cycle compare strobes and window against the scoreboard.
  always @(negedge clk) begin
    if (monOn) begin
      logic expRd, expBad, expDone;
      ev_t e;
      expRd = 1'b0; expBad = 1'b0; expDone = 1'b0;
      if (rdQ.size() > 0 && rdQ[0] < cyc) begin
        chk("rd_missed", 32'(rdQ[0]), 32'(cyc));
        void'(rdQ.pop_front());
      end
      if (evQ.size() > 0 && evQ[0].cyc < cyc) begin
        chk("ev_missed", 32'(evQ[0].cyc), 32'(cyc));
        void'(evQ.pop_front());
      end
      if (rdQ.size() > 0 && rdQ[0] == cyc) begin
        expRd = 1'b1;
        void'(rdQ.pop_front());
      end
      if (evQ.size() > 0 && evQ[0].cyc == cyc) begin
        e = evQ.pop_front();
        curWin  = e.win;
        curBusy = e.busy;
        expBad  = e.bad;
        expDone = e.done;
      end
      chk("rd_en",    32'(o_fifo_rd_en), 32'(expRd));
      chk("window",   32'(o_window),     32'(curWin));
      chk("busy",     32'(o_busy),       32'(curBusy));
      chk("bad_char", 32'(o_bad_char),   32'(expBad));
      chk("done",     32'(o_done),       32'(expDone));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) step();
  endtask

  task automatic pushByte(input logic [7:0] b);
    fifoQ.push_back(b);
    mFifo.push_back(b);
  endtask

  // Reference rules for an accepted tick at cycle n.
  task automatic modelTick(input int n);
    logic [7:0] b;
    logic [3:0] code;
    logic       bad;
    if (!mRun || i_pause) return;
    if (mFifo.size() > 0) begin
      b = mFifo.pop_front();
      rdQ.push_back(n + 1);
      mCnt = (mCnt + 1) % 256;
      bad  = !(b >= 8'h30 && b <= 8'h39);
      code = bad ? BLANK : 4'(b - 8'h30);
      mWin = {mWin[WBITS-5:0], code};
      mDrain = 0;
      pushEv(n + 3, mWin, 1'b1, bad, 1'b0);
    end else begin
      mWin = {mWin[WBITS-5:0], BLANK};
      mDrain++;
      if (mDrain == DIGITS) begin
        mRun = 0;
        pushEv(n + 1, mWin, 1'b0, 1'b0, 1'b1);
      end else begin
        pushEv(n + 1, mWin, 1'b1, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic pulseTick();
    i_tick = 1'b1;
    modelTick(cyc);
    step();
    i_tick = 1'b0;
  endtask

  task automatic doStart();
    i_start = 1'b1;
    if (!mRun) begin
      mRun = 1; mCnt = 0; mDrain = 0;
      pushEv(cyc + 1, mWin, 1'b1, 1'b0, 1'b0);
    end
    step();
    i_start = 1'b0;
  endtask

  task automatic doAbort();
    int n;
    n = cyc;
    i_abort = 1'b1;
    while (evQ.size() > 0 && evQ[evQ.size()-1].cyc > n) void'(evQ.pop_back());
    mRun = 0; mWin = WIN_BLANK; mCnt = 0; mDrain = 0;
    pushEv(n + 1, WIN_BLANK, 1'b0, 1'b0, 1'b0);
    step();
    i_abort = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    idle(3);
    chk("rst_window", 32'(o_window), 32'(12'hFFF));
    chk("rst_busy",   32'(o_busy), 32'd0);
    chk("rst_rd_en",  32'(o_fifo_rd_en), 32'd0);
    chk("rst_cnt",    32'(o_char_cnt), 32'd0);
    chk("rst_done",   32'(o_done | o_bad_char), 32'd0);
    rst_n = 1'b1;
    curWin = WIN_BLANK; curBusy = 1'b0;
    monOn = 1;
    idle(2);

    // "123" at a 10-cycle tick rate, then drain to done.
    pushByte("1"); pushByte("2"); pushByte("3");
    idle(2);
    doStart();
    pulseTick(); idle(9); chk("win_ff1", 32'(o_window), 32'(12'hFF1));
    pulseTick(); idle(9); chk("win_f12", 32'(o_window), 32'(12'hF12));
    pulseTick(); idle(9); chk("win_123", 32'(o_window), 32'(12'h123));
    chk("cnt_3", 32'(o_char_cnt), 32'd3);
    pulseTick(); idle(9); chk("win_23f", 32'(o_window), 32'(12'h23F));
    pulseTick(); idle(9); chk("win_3ff", 32'(o_window), 32'(12'h3FF));
    pulseTick(); idle(9); chk("win_fff", 32'(o_window), 32'(12'hFFF));
    chk("busy_fall", 32'(o_busy), 32'd0);

    // Non-digit byte.
    pushByte(8'h41); idle(2);
    doStart();
    pulseTick(); idle(5);
    chk("bad_slot0", 32'(o_window[3:0]), 32'hF);
    repeat (3) begin pulseTick(); idle(4); end
    chk("bad_drain_idle", 32'(o_busy), 32'd0);

    // Pause held across two ticks.
    pushByte("5"); pushByte("6"); idle(2);
    doStart();
    pulseTick(); idle(4);
    i_pause = 1'b1; idle(1);
    pulseTick(); idle(4);
    pulseTick(); idle(4);
    chk("pause_hold", 32'(o_window), 32'(12'hFF5));
    i_pause = 1'b0; idle(1);
    pulseTick(); idle(4);
    chk("pause_release", 32'(o_window), 32'(12'hF56));
    chk("pause_cnt", 32'(o_char_cnt), 32'd2);

    // Abort in the READ cycle.
    pushByte("7"); pushByte("8"); idle(2);
    pulseTick();
    doAbort();
    idle(4);
    chk("abort_win",  32'(o_window), 32'(12'hFFF));
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_cnt",  32'(o_char_cnt), 32'd0);
    doStart();
    pulseTick(); idle(4);
    chk("abort_resume", 32'(o_window), 32'(12'hFF8));
    repeat (3) begin pulseTick(); idle(4); end

    // Asynchronous reset in CAPTURE.
    pushByte("9"); pushByte("4"); idle(2);
    doStart();
    pulseTick(); step();
    monOn = 0;
    rst_n = 1'b0;
    #1;
    chk("arst_window", 32'(o_window), 32'(12'hFFF));
    chk("arst_busy",   32'(o_busy), 32'd0);
    chk("arst_rd_en",  32'(o_fifo_rd_en), 32'd0);
    chk("arst_cnt",    32'(o_char_cnt), 32'd0);
    evQ.delete(); rdQ.delete();
    mRun = 0; mWin = WIN_BLANK; mCnt = 0; mDrain = 0;
    curWin = WIN_BLANK; curBusy = 1'b0;
    idle(2);
    rst_n = 1'b1;
    monOn = 1;
    pulseTick(); idle(4);
    pulseTick(); idle(4);
    doStart();
    pulseTick(); idle(4);
    chk("arst_resume", 32'(o_window), 32'(12'hFF4));

    // Randomized traffic against the reference rules.
    for (int it = 0; it < 300; it++) begin
      chk("rand_cnt", 32'(o_char_cnt), 32'(mCnt));
      case ($urandom_range(0, 9))
        0, 1: begin
          for (int k = 0; k < int'($urandom_range(1, 3)); k++)
            pushByte(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'h30 + $urandom_range(0, 9)));
          idle(2);
        end
        2: begin doStart(); idle(1); end
        3: begin i_pause = ~i_pause; idle(1); end
        4: begin
          if ($urandom_range(0, 4) == 0) doAbort();
          idle(2);
        end
        default: begin pulseTick(); idle($urandom_range(2, 6)); end
      endcase
    end

    i_pause = 1'b0;
    idle(1);
    guard = 0;
    while (mRun && guard < 200) begin
      pulseTick(); idle(3);
      guard++;
    end
    idle(5);
    chk("final_cnt",  32'(o_char_cnt), 32'(mCnt));
    chk("final_busy", 32'(o_busy), 32'd0);
    chk("sb_drained", 32'(evQ.size() + rdQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
